wishbone_mem_slave: RTL and testbench



---
 rtl/wishbone_mem_slave_pkg.sv | 19 +
 rtl/wishbone_mem_slave_if.sv | 27 ++
 rtl/wishbone_mem_slave_ram.sv | 35 +++
 rtl/wishbone_mem_slave.sv | 171 +++++++++++++++++
 tb/tb_wishbone_mem_slave.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_mem_slave_pkg.sv
// Shared definitions for the Wishbone memory responder.
// Contents: FSM state encoding, bus widths, and the data value returned
// for reads that fall outside the implemented memory.
package wishbone_pkg;

   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_SEL_WIDTH  = 4;
   localparam int WB_CNT_WIDTH  = 4;

   localparam logic [WB_DATA_WIDTH-1:0] WB_OOR_READ_VALUE = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } wb_state_e;

endpackage

// File: rtl/wishbone_mem_slave_if.sv
// Wishbone classic-cycle bus bundle between one master and the memory responder.
// Signals: we/cyc/stb/sel/adr/dat_i driven by the master; dat_o/ack/int
// driven by the responder. Names keep the responder-side _i/_o suffixes.
interface wishbone_mem_slave_if;
   import wishbone_pkg::*;

   logic                     wbs_we_i;
   logic                     wbs_cyc_i;
   logic                     wbs_stb_i;
   logic [WB_SEL_WIDTH-1:0]  wbs_sel_i;
   logic [31:0]              wbs_adr_i;
   logic [WB_DATA_WIDTH-1:0] wbs_dat_i;
   logic [WB_DATA_WIDTH-1:0] wbs_dat_o;
   logic                     wbs_ack_o;
   logic                     wbs_int_o;

   modport slave (
      input  wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o, wbs_int_o
   );

   modport master (
      output wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o, wbs_int_o
   );

endinterface

// File: rtl/wishbone_mem_slave_ram.sv
// Single-port byte-writable RAM with a registered (one-cycle) read, written
// so synthesis can map it onto block RAM. No reset on the array or read data.
// Ports: clk; addr_i word address; re_i loads rdata_o from addr_i;
// be_i per-byte write enables; wdata_i write data; rdata_o read data.
module wishbone_mem_slave_ram
   import wishbone_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic [ADDR_WIDTH-1:0]    addr_i,
   input  logic                     re_i,
   input  logic [WB_SEL_WIDTH-1:0]  be_i,
   input  logic [WB_DATA_WIDTH-1:0] wdata_i,
   output logic [WB_DATA_WIDTH-1:0] rdata_o
);

   logic [WB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [WB_DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
      for (int b = 0; b < WB_SEL_WIDTH; b++) begin
         if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_mem_slave.sv
// Wishbone classic-cycle memory responder: word-addressed 32-bit RAM with
// byte lanes, WAIT_STATES cycles between accept and a single-cycle ack, and
// an ack (with zero read data, discarded write) for out-of-range addresses.
// Ports: clk; rst (synchronous, active-high); wbs (slave modport of
// wishbone_mem_slave_if).
// Optional build macro WISHBONE_MEM_SLAVE_INT_EN: word MEM_DEPTH-1 becomes a
// doorbell; a write sets wbs_int_o, a read clears it. Without the macro
// wbs_int_o is tied low.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for cyc&stb; latches the request on accept
// ST_WAIT    | counting wait states down; cyc low aborts the transfer
// ST_ACK     | ack high for one cycle; write commits, read data shown
// ST_RELEASE | waiting for cyc or stb to drop before the next transfer
module wishbone_mem_slave
   import wishbone_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   wishbone_mem_slave_if.slave wbs
);

   wb_state_e                state_q, state_d;
   logic [WB_CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]              adr_q;
   logic                     we_q;
   logic [WB_SEL_WIDTH-1:0]  sel_q;
   logic [WB_DATA_WIDTH-1:0] wdat_q;
   logic [WB_DATA_WIDTH-1:0] dat_q;

   logic                     req;
   logic                     accept;
   logic                     in_range;
   logic                     ack;
   logic [WB_DATA_WIDTH-1:0] rd_dat;
   logic                     ram_re;
   logic [WB_SEL_WIDTH-1:0]  ram_be;
   logic [ADDR_WIDTH-1:0]    ram_addr;
   logic [WB_DATA_WIDTH-1:0] ram_rdata;

   assign req      = wbs.wbs_cyc_i && wbs.wbs_stb_i;
   assign in_range = adr_q < 32'(MEM_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WB_CNT_WIDTH'(WAIT_STATES);
               end
            end
         end
         ST_WAIT: begin
            if (!wbs.wbs_cyc_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == WB_CNT_WIDTH'(1)) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK:     state_d = ST_RELEASE;
         ST_RELEASE: if (!req) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // The RAM read is launched on the edge that enters ST_ACK so the word is
   // on ram_rdata during the ack cycle. In ST_IDLE the request is not yet
   // latched, so the live bus address feeds the RAM (matters for 0 wait states).
   always_comb begin
      ack      = 1'b0;
      rd_dat   = dat_q;
      ram_re   = (state_d == ST_ACK) && (state_q != ST_ACK);
      ram_be   = '0;
      ram_addr = (state_q == ST_IDLE) ? wbs.wbs_adr_i[ADDR_WIDTH-1:0]
                                      : adr_q[ADDR_WIDTH-1:0];
      if (state_q == ST_ACK) begin
         ack = 1'b1;
         if (!we_q) begin
            rd_dat = in_range ? ram_rdata : WB_OOR_READ_VALUE;
         end else if (in_range && !rst) begin
            ram_be = sel_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         adr_q  <= '0;
         we_q   <= 1'b0;
         sel_q  <= '0;
         wdat_q <= '0;
         dat_q  <= '0;
      end else begin
         if (accept) begin
            adr_q  <= wbs.wbs_adr_i;
            we_q   <= wbs.wbs_we_i;
            sel_q  <= wbs.wbs_sel_i;
            wdat_q <= wbs.wbs_dat_i;
         end
         // Read data is held between reads; only reset or an out-of-range read clears it.
         if ((state_q == ST_ACK) && !we_q) begin
            dat_q <= rd_dat;
         end
      end
   end

   wishbone_mem_slave_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk     (clk),
      .addr_i  (ram_addr),
      .re_i    (ram_re),
      .be_i    (ram_be),
      .wdata_i (wdat_q),
      .rdata_o (ram_rdata)
   );

   assign wbs.wbs_ack_o = ack;
   assign wbs.wbs_dat_o = rd_dat;

`ifdef WISHBONE_MEM_SLAVE_INT_EN
   logic int_q;
   logic is_bell;

   assign is_bell = adr_q == 32'(MEM_DEPTH - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         int_q <= 1'b0;
      end else if ((state_q == ST_ACK) && is_bell) begin
         if (!we_q) begin
            int_q <= 1'b0;
         end else if (sel_q != '0) begin
            int_q <= 1'b1;
         end
      end
   end

   assign wbs.wbs_int_o = int_q;
`else
   assign wbs.wbs_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_mem_slave.sv
// Bench for wishbone_mem_slave: one instance with 1 wait state, one with 4.
// Stimulus pushes expected acks (cycle, read data, interrupt level after the
// ack) into per-instance queues; monitors pop and compare on every ack.
module tb_wishbone_mem_slave;
   import wishbone_pkg::*;

`ifdef WISHBONE_MEM_SLAVE_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      bit          rd;
      logic [31:0] dat;
      bit          intv;
   } exp_t;

   logic clk = 1'b0;
   logic rst1, rst4;
   int   cyc_cnt = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q1[$];
   exp_t q4[$];
   bit   pend [2];
   bit   pend_int [2];
   bit   int_m [2];

   wishbone_mem_slave_if bus1 ();
   wishbone_mem_slave_if bus4 ();

   wishbone_mem_slave #(.ADDR_WIDTH(10), .MEM_DEPTH(1024), .WAIT_STATES(1)) dut1 (
      .clk (clk), .rst (rst1), .wbs (bus1.slave));
   wishbone_mem_slave #(.ADDR_WIDTH(10), .MEM_DEPTH(1024), .WAIT_STATES(4)) dut4 (
      .clk (clk), .rst (rst4), .wbs (bus4.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (d == 0) begin
         bus1.wbs_cyc_i = cyc; bus1.wbs_stb_i = stb; bus1.wbs_we_i = we;
         bus1.wbs_adr_i = adr; bus1.wbs_dat_i = dat; bus1.wbs_sel_i = sel;
      end else begin
         bus4.wbs_cyc_i = cyc; bus4.wbs_stb_i = stb; bus4.wbs_we_i = we;
         bus4.wbs_adr_i = adr; bus4.wbs_dat_i = dat; bus4.wbs_sel_i = sel;
      end
   endtask

   function automatic logic ack_of(input int d);
      return (d == 0) ? bus1.wbs_ack_o : bus4.wbs_ack_o;
   endfunction

   task automatic mon(input int d, input logic ack, input logic [31:0] dat, input logic intr);
      exp_t e;
      if (pend[d]) begin
         chk("int_after_ack", 32'(intr), 32'(pend_int[d]));
         pend[d] = 1'b0;
      end
      if (ack === 1'b1) begin
         if (d == 0 && q1.size() > 0) e = q1.pop_front();
         else if (d == 1 && q4.size() > 0) e = q4.pop_front();
         else begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack dut=%0d actual=1 expected=0 (cycle %0d)", d, cyc_cnt);
            return;
         end
         chk("ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
         if (e.rd) chk("read_data", dat, e.dat);
         pend[d]     = 1'b1;
         pend_int[d] = e.intv;
      end
   endtask

   always @(negedge clk) mon(0, bus1.wbs_ack_o, bus1.wbs_dat_o, bus1.wbs_int_o);
   always @(negedge clk) mon(1, bus4.wbs_ack_o, bus4.wbs_dat_o, bus4.wbs_int_o);

   // Issue one request, push its expectation, scramble the bus after accept,
   // wait (bounded) for ack, optionally hold the strobe, then drop it.
   task automatic xfer(input int d, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input int hold);
      exp_t e;
      int   ws;
      bit   got;
      ws = (d == 0) ? 1 : 4;
      @(posedge clk); #1;
      drive(d, 1'b1, 1'b1, we, adr, dat, sel);
      if (INT_EN && adr == 32'h3FF) begin
         if (!we) int_m[d] = 1'b0;
         else if (sel != 4'h0) int_m[d] = 1'b1;
      end
      e.cyc  = cyc_cnt + 1 + ws;
      e.rd   = !we;
      e.dat  = exp;
      e.intv = int_m[d];
      if (d == 0) q1.push_back(e); else q4.push_back(e);
      @(posedge clk); #1;
      drive(d, 1'b1, 1'b1, we, ~adr, ~dat, ~sel);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (ack_of(d) === 1'b1) got = 1'b1;
      end
      if (!got) chk("ack_timeout", 32'(got), 32'd1);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acks;
      bit  got;
      exp_t e;
      rst1 = 1'b1;
      rst4 = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      rst1 = 1'b0;
      rst4 = 1'b0;
      @(negedge clk);
      chk("reset_ack", 32'(bus1.wbs_ack_o), 32'd0);
      chk("reset_dat", bus1.wbs_dat_o, 32'h0);
      chk("reset_int", 32'(bus1.wbs_int_o), 32'd0);

      // basic write / read, then read data must hold
      xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
      @(negedge clk);
      chk("dat_hold", bus1.wbs_dat_o, 32'hDEADBEEF);

      // byte lanes
      xfer(0, 1, 32'h5, 32'h11223344, 4'hF, 32'h0, 0);
      xfer(0, 1, 32'h5, 32'hAABBCCDD, 4'h5, 32'h0, 0);
      xfer(0, 0, 32'h5, 32'h0, 4'hF, 32'h11BB33DD, 0);

      // sel = 0 write leaves the word alone
      xfer(0, 1, 32'h10, 32'h00000000, 4'h0, 32'h0, 0);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);

      // out of range
      xfer(0, 1, 32'h0,   32'h01234567, 4'hF, 32'h0, 0);
      xfer(0, 1, 32'h3FF, 32'h5A5A5A5A, 4'hF, 32'h0, 0);
      xfer(0, 0, 32'h400, 32'h0, 4'hF, 32'h00000000, 0);
      @(negedge clk);
      chk("oor_dat_cleared", bus1.wbs_dat_o, 32'h0);
      xfer(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
      xfer(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
      xfer(0, 0, 32'h3FF, 32'h0, 4'hF, 32'h5A5A5A5A, 0);
      xfer(0, 0, 32'h0,   32'h0, 4'hF, 32'h01234567, 0);

      // doorbell word (ordinary RAM when the feature is off)
      xfer(0, 1, 32'h3FF, 32'h00000001, 4'hF, 32'h0, 0);
      xfer(0, 0, 32'h3FF, 32'h0, 4'hF, 32'h00000001, 0);

      // held strobe: one ack, then a second after a one-cycle drop
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 10);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);

      // reset during the ack of a read
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 4'hF);
      e.cyc = cyc_cnt + 2; e.rd = 1'b1; e.dat = 32'h11BB33DD; e.intv = 1'b0;
      q1.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus1.wbs_ack_o === 1'b1) got = 1'b1;
      end
      if (!got) chk("ack_timeout_rst", 32'(got), 32'd1);
      rst1 = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("rst_ack", 32'(bus1.wbs_ack_o), 32'd0);
      chk("rst_dat", bus1.wbs_dat_o, 32'h0);
      chk("rst_int", 32'(bus1.wbs_int_o), 32'd0);
      int_m[0] = 1'b0;
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);

      // four wait states: normal write, aborted write, readback
      xfer(1, 1, 32'h20, 32'h0BADF00D, 4'hF, 32'h0, 0);
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus4.wbs_ack_o === 1'b1) acks++;
      end
      chk("abort_no_ack", 32'(acks), 32'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      xfer(1, 0, 32'h20, 32'h0, 4'hF, 32'h0BADF00D, 0);

      repeat (4) @(negedge clk);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
